pot_scan_ctrl: RTL

- Round-robin scheduler that owns the single shared A2D converter and keeps the six equalizer pot registers (LP, B1, B2, B3, HP, VOL) current for the core datapath.
- Issues one conversion at a time, captures each result into the matching pot register, and inserts a settling gap between conversions.
- Enforces a per-conversion timeout so a stuck A2D cannot freeze the gains.
- Sits between the A2D SPI interface and the core's *_pot inputs.

---
 rtl/pot_scan_ctrl_pkg.sv | 34 +++
 rtl/pot_scan_ctrl_if.sv | 11 +
 rtl/pot_scan_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pot_scan_ctrl_pkg.sv
// Shared types and constants for the equalizer pot scanner: FSM states, slot
// order and the slot-to-A2D-channel map.
package eq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SLOT_LP  = 3'd0,
    SLOT_B1  = 3'd1,
    SLOT_B2  = 3'd2,
    SLOT_B3  = 3'd3,
    SLOT_HP  = 3'd4,
    SLOT_VOL = 3'd5
  } slot_e;

  localparam int NUM_POTS = 6;

  // A2D channel wired to each pot, indexed by slot.
  localparam logic [2:0] CHNL_MAP [NUM_POTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  function automatic slot_e next_slot(slot_e s);
    return (s == SLOT_VOL) ? SLOT_LP : slot_e'(s + 3'd1);
  endfunction

  function automatic logic [2:0] chnl_of(slot_e s);
    return (s > SLOT_VOL) ? CHNL_MAP[0] : CHNL_MAP[int'(s)];
  endfunction

endpackage

// File: rtl/pot_scan_ctrl_if.sv
// A2D conversion handshake: strt_cnv/chnnl request, cnv_cmplt/res completion.
// strt_cnv is a one-cycle request; res is only meaningful while cnv_cmplt=1.
interface pot_scan_ctrl_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/pot_scan_ctrl.sv
// Round-robin owner of the shared A2D: converts the six pot channels in turn,
// latches each result into its pot register and flags conversion timeouts.
module pot_scan_ctrl
  import eq_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic              clr_err,
  pot_scan_ctrl_if.master   a2d,
  output logic [11:0]       LP_pot,
  output logic [11:0]       B1_pot,
  output logic [11:0]       B2_pot,
  output logic [11:0]       B3_pot,
  output logic [11:0]       HP_pot,
  output logic [11:0]       VOL_pot,
  output logic              scan_done,
  output logic              err_flag,
  output state_e            dbg_state_o
);

  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  slot_e             slot_q, slot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        chnl_q;
  logic              err_q, err_d;
  logic [11:0]       pot_q [NUM_POTS];
  logic              capture;
  logic              strt;
  logic              done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= SLOT_LP;
      cnt_q   <= '0;
      chnl_q  <= CHNL_MAP[0];
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      chnl_q  <= chnl_of(slot_d);
      err_q   <= err_d;
    end
  end

  // One shared counter: conversion timeout in WAIT, settling time in GAP.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    capture = 1'b0;
    strt    = 1'b0;
    done    = 1'b0;
    if (clr_err) err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scan_en) state_d = START;
      end
      START: begin
        strt    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (a2d.cnv_cmplt) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          slot_d  = next_slot(slot_q);
          done    = (slot_q == SLOT_VOL);
          cnt_d   = '0;
          state_d = scan_en ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pot bank: only the register of the slot under conversion is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_POTS; i++) pot_q[i] <= 12'h000;
    end else begin
      for (int i = 0; i < NUM_POTS; i++) begin
        if (capture && (int'(slot_q) == i)) pot_q[i] <= a2d.res;
      end
    end
  end

  assign a2d.strt_cnv = strt;
  assign a2d.chnnl    = chnl_q;
  assign scan_done    = done;
  assign err_flag     = err_q;
  assign dbg_state_o  = state_q;

  assign LP_pot  = pot_q[SLOT_LP];
  assign B1_pot  = pot_q[SLOT_B1];
  assign B2_pot  = pot_q[SLOT_B2];
  assign B3_pot  = pot_q[SLOT_B3];
  assign HP_pot  = pot_q[SLOT_HP];
  assign VOL_pot = pot_q[SLOT_VOL];

endmodule
